// File: rtl/rsa_stream_loader_if.sv
// Bundle of the byte-stream, key-control and core-side signals around the
// RSA stream loader.
//   rx_*        : 8-bit valid/ready stream from the receive path into the loader
//   tx_*        : 8-bit valid/ready stream from the loader to the transmit path
//   key_reload  : request to load a new modulus and exponent
//   core_*      : operands, start pulse, result and done pulse of the exp core
//   busy        : loader is starting, waiting on, or draining a core run
// Modport slave is the loader itself; modport master is its surroundings.
interface rsa_stream_loader_if #(
  parameter int W = 256
);
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         key_reload;
  logic         core_start;
  logic [W-1:0] core_a;
  logic [W-1:0] core_e;
  logic [W-1:0] core_n;
  logic [W-1:0] core_result;
  logic         core_finished;
  logic         busy;

  modport slave (
    input  rx_data, rx_valid, tx_ready, key_reload, core_result, core_finished,
    output rx_ready, tx_data, tx_valid, core_start, core_a, core_e, core_n, busy
  );

  modport master (
    output rx_data, rx_valid, tx_ready, key_reload, core_result, core_finished,
    input  rx_ready, tx_data, tx_valid, core_start, core_a, core_e, core_n, busy
  );
endinterface

// File: rtl/rsa_stream_loader.sv
// Byte-stream front end for the RSA exponentiation core (a^e mod n).
// Receives modulus N, exponent E and then repeated base blocks A, MSB byte
// first, on an 8-bit valid/ready input. For each A block it pulses the core
// start, waits for the core to finish, and streams the low OUT_BYTES bytes of
// the result out MSB first. N and E are kept across blocks until a reload.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rsa_stream_loader_if (streams, key reload, core I/O)
module rsa_stream_loader #(
  parameter int W         = 256,
  parameter int IN_BYTES  = W / 8,
  parameter int OUT_BYTES = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  rsa_stream_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_E,
    S_GET_A,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  localparam logic [5:0] IN_LAST  = 6'(IN_BYTES - 1);
  localparam logic [5:0] OUT_LAST = 6'(OUT_BYTES - 1);
  localparam int         OUT_MSB  = OUT_BYTES * 8 - 1;

  state_t       state;
  logic [5:0]   cnt_reg;
  logic [W-1:0] n_reg;
  logic [W-1:0] e_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] result_reg;
  // {rx_ready, tx_valid, core_start, busy}, loaded together with the state so
  // every handshake output comes straight from a flop.
  logic [3:0]   flags_reg;

  logic rx_fire;
  logic tx_fire;

  function automatic logic [3:0] flags_for(input state_t s);
    case (s)
      S_GET_N, S_GET_E, S_GET_A: flags_for = 4'b1000;
      S_START:                   flags_for = 4'b0011;
      S_WAIT:                    flags_for = 4'b0001;
      S_SEND:                    flags_for = 4'b0101;
      default:                   flags_for = 4'b1000;
    endcase
  endfunction

  assign rx_fire = bus.rx_valid && flags_reg[3];
  assign tx_fire = flags_reg[2] && bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_GET_N;
      flags_reg  <= 4'b1000;
      cnt_reg    <= '0;
      n_reg      <= '0;
      e_reg      <= '0;
      a_reg      <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        S_GET_N: begin
          if (rx_fire) begin
            n_reg <= {n_reg[W-9:0], bus.rx_data};
            if (cnt_reg == IN_LAST) begin
              cnt_reg   <= '0;
              state     <= S_GET_E;
              flags_reg <= flags_for(S_GET_E);
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end
        end

        S_GET_E: begin
          if (rx_fire) begin
            e_reg <= {e_reg[W-9:0], bus.rx_data};
            if (cnt_reg == IN_LAST) begin
              cnt_reg   <= '0;
              state     <= S_GET_A;
              flags_reg <= flags_for(S_GET_A);
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end
        end

        S_GET_A: begin
          if (rx_fire) begin
            // An accepted byte always takes priority over a reload request.
            a_reg <= {a_reg[W-9:0], bus.rx_data};
            if (cnt_reg == IN_LAST) begin
              cnt_reg   <= '0;
              state     <= S_START;
              flags_reg <= flags_for(S_START);
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end else if (bus.key_reload && (cnt_reg == '0)) begin
            // Reload only between blocks, never in the middle of an A block.
            n_reg     <= '0;
            e_reg     <= '0;
            state     <= S_GET_N;
            flags_reg <= flags_for(S_GET_N);
          end
        end

        S_START: begin
          state     <= S_WAIT;
          flags_reg <= flags_for(S_WAIT);
        end

        S_WAIT: begin
          // The done pulse is only meaningful here; a pulse from a run that
          // was aborted by reset lands in another state and is dropped.
          if (bus.core_finished) begin
            result_reg <= bus.core_result;
            cnt_reg    <= '0;
            state      <= S_SEND;
            flags_reg  <= flags_for(S_SEND);
          end
        end

        S_SEND: begin
          if (tx_fire) begin
            result_reg <= result_reg << 8;
            if (cnt_reg == OUT_LAST) begin
              cnt_reg   <= '0;
              state     <= S_GET_A;
              flags_reg <= flags_for(S_GET_A);
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end
        end

        default: begin
          cnt_reg   <= '0;
          state     <= S_GET_N;
          flags_reg <= flags_for(S_GET_N);
        end
      endcase
    end
  end

  assign bus.rx_ready   = flags_reg[3];
  assign bus.tx_valid   = flags_reg[2];
  assign bus.core_start = flags_reg[1];
  assign bus.busy       = flags_reg[0];
  // The byte on the wire only moves when the shift register moves, so it is
  // stable for as long as the receiver stalls.
  assign bus.tx_data    = result_reg[OUT_MSB -: 8];
  assign bus.core_a     = a_reg;
  assign bus.core_e     = e_reg;
  assign bus.core_n     = n_reg;

endmodule
